keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Scan controller for the 4x4 matrix keypad.
- Drives the column lines one at a time and reads the row lines after they pass through the two-flop input synchronizer.
- Debounces press and release, and emits one 4-bit hex key code with a single-cycle valid strobe per physical press.
- Its outputs feed the display and key-history logic downstream.

Parameters:
- SCAN_CYCLES, 4, clocks each column is driven before the rows are sampled and the scan advances (≥3, covers the 2-cycle synchronizer latency).
- DEBOUNCE_CYCLES, 20000, consecutive stable clocks required to accept a press or a release (≥1).
- CNT_W, 16, counter width; must hold max(SCAN_CYCLES, DEBOUNCE_CYCLES).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rows_sync  in  4  synchronized row lines, active-low (0 = row pulled low by a pressed key)
- cols  out  4  column drive, active-low one-cold (exactly one bit 0 outside reset)
- key_code  out  4  hex code of the last accepted key
- key_valid  out  1  one-cycle strobe when a new key is accepted
- key_held  out  1  high while the accepted key is still pressed, including release debounce

Behaviour:
- Reset (reset=1 at a clk edge): state=SCAN, col index=0, cols=4'b1110, counter=0, key_code=0, key_valid=0, key_held=0. Reset mid-debounce or mid-hold aborts without a strobe.
- Key map, row r / col c, gives a hex code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
  - cols[c]=0 drives column c.
- SCAN:
  - Hold column c for SCAN_CYCLES clocks.
  - On the last clock of the dwell, sample rows_sync.
  - If exactly one row bit is 0: latch the row/col, clear the counter, go to PRESS_DB, keep column c driven.
  - If zero rows or more than one row are low: col index=(c+1) mod 4 (3 wraps to 0), counter=0.
- PRESS_DB:
  - Each clock, if rows_sync equals the latched pattern, the counter increments; otherwise return to SCAN at the next column with no strobe.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the pattern still matching: go to HELD. On the same edge, key_code=mapped code, key_valid=1 for exactly that one cycle, key_held=1.
- HELD:
  - Column stays frozen.
  - While the latched row bit is 0, remain.
  - When it becomes 1, go to REL_DB with counter=0.
  - Other keys are ignored: their columns are not driven, and other rows going low on the same column are also ignored.
- REL_DB:
  - If the latched row bit returns to 0 (bounce), go back to HELD with no new strobe.
  - After DEBOUNCE_CYCLES consecutive clocks with the bit at 1: key_held=0, go to SCAN at the next column.
- key_code holds its value until the next accepted press.
- Latency from a stable press to key_valid: at most 4·SCAN_CYCLES + DEBOUNCE_CYCLES + 2 clocks.
- The counter never exceeds its terminal value; no width overflow for legal parameters.

Test Plan (bench uses SCAN_CYCLES=4, DEBOUNCE_CYCLES=4, keypad model pulls row r low when cols[c]=0 and key (r,c) is pressed):
- Reset: hold reset 2 cycles -> cols=4'b1110, key_code=0, key_valid=0, key_held=0; with no keys, cols cycles 1110→1101→1011→0111→1110, each for 4 clocks.
- Clean press of key "5" (r1,c1) for 40 clocks -> exactly one key_valid pulse with key_code=4'h5, key_held=1 until 4 clocks after release, then scanning resumes at cols=4'b1011.
- Bouncy press of "D" (r3,c3): 2-clock low, 1-clock high, then stable low -> no strobe on the bounce, then a single strobe with key_code=4'hD.
- Release bounce on "0": while held, rows toggle high for 2 clocks then low again -> no second key_valid; key_held stays 1.
- Second key while held: hold "1" (r0,c0), then also press "3" (r0,c2) -> no strobe for 3 and key_code stays 1. After releasing both, pressing "3" alone -> strobe with key_code=4'h3.
- Two rows low on one column ("2" and "8" together) -> no strobe, scan keeps advancing. Assert reset during PRESS_DB of "A" -> no strobe, cols=4'b1110 on the next cycle.

Source files
------------

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scan bundle: synchronized row inputs, column drive and the accepted-key outputs.
// master is the scan controller; slave is the keypad/consumer side.
interface keypad_scan_ctrl_if;
  logic [3:0] rows_sync;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  rows_sync,
    output cols,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output rows_sync,
    input  cols,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces press and release,
// and strobes one hex key code per accepted press.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 16
) (
  input logic                 clk,
  input logic                 reset,
  keypad_scan_ctrl_if.master  kp
);

  localparam logic [CNT_W-1:0] ScanLast = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StPressDb, StHeld, StRelDb} state_e;

  state_e           state_q;
  logic [1:0]       col_q;
  logic [1:0]       row_idx_q;
  logic [3:0]       row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       code_q;
  logic             valid_q;
  logic             held_q;

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [3:0] v);
    unique case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    unique case (v)
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    unique case ({r, c})
      4'b0000: key_map = 4'h1;
      4'b0001: key_map = 4'h2;
      4'b0010: key_map = 4'h3;
      4'b0011: key_map = 4'hA;
      4'b0100: key_map = 4'h4;
      4'b0101: key_map = 4'h5;
      4'b0110: key_map = 4'h6;
      4'b0111: key_map = 4'hB;
      4'b1000: key_map = 4'h7;
      4'b1001: key_map = 4'h8;
      4'b1010: key_map = 4'h9;
      4'b1011: key_map = 4'hC;
      4'b1100: key_map = 4'hE;
      4'b1101: key_map = 4'h0;
      4'b1110: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StScan;
      col_q     <= 2'd0;
      row_idx_q <= 2'd0;
      row_q     <= 4'hF;
      cnt_q     <= '0;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (cnt_q == ScanLast) begin
            cnt_q <= '0;
            if (single_low(kp.rows_sync)) begin
              row_q     <= kp.rows_sync;
              row_idx_q <= low_index(kp.rows_sync);
              state_q   <= StPressDb;
            end else begin
              col_q <= col_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPressDb: begin
          // Any change in the full row pattern, including a second row, aborts the press.
          if (kp.rows_sync == row_q) begin
            if (cnt_q == DbLast) begin
              state_q <= StHeld;
              code_q  <= key_map(row_idx_q, col_q);
              valid_q <= 1'b1;
              held_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            state_q <= StScan;
            col_q   <= col_q + 2'd1;
            cnt_q   <= '0;
          end
        end
        StHeld: begin
          // Only the latched row bit matters; column stays frozen so other keys are invisible.
          if (kp.rows_sync[row_idx_q]) begin
            state_q <= StRelDb;
            cnt_q   <= '0;
          end
        end
        StRelDb: begin
          if (!kp.rows_sync[row_idx_q]) begin
            state_q <= StHeld;
            cnt_q   <= '0;
          end else if (cnt_q == DbLast) begin
            state_q <= StScan;
            held_q  <= 1'b0;
            col_q   <= col_q + 2'd1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StScan;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign kp.cols      = ~(4'b0001 << col_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix on the column drive.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  rows_m;
  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  logic [3:0]  last_code = 4'h0;
  int          base;

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kif)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rows_m = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && kif.cols[c] == 1'b0) rows_m[r] = 1'b0;
      end
    end
  end
  assign kif.rows_sync = rows_m;

  always @(negedge clk) begin
    if (kif.key_valid === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      last_code <= kif.key_code;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cols(input logic [3:0] target);
    int n = 0;
    while (kif.cols !== target && n < 40) begin
      step(1);
      n++;
    end
    chk("wait_cols_timeout", 32'(n < 40), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_cols [4];
    exp_cols[0] = 4'b1110;
    exp_cols[1] = 4'b1101;
    exp_cols[2] = 4'b1011;
    exp_cols[3] = 4'b0111;

    // Reset and idle scan
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("rst_cols", 32'(kif.cols), 32'hE);
    chk("rst_code", 32'(kif.key_code), 32'h0);
    chk("rst_valid", 32'(kif.key_valid), 32'h0);
    chk("rst_held", 32'(kif.key_held), 32'h0);
    for (int k = 0; k < 16; k++) begin
      chk("idle_scan_cols", 32'(kif.cols), 32'(exp_cols[k/4]));
      step(1);
    end

    // Clean press of 5 (r1,c1)
    base = valid_cnt;
    pressed = 16'h0001 << 5;
    step(40);
    chk("k5_strobes", 32'(valid_cnt - base), 32'd1);
    chk("k5_strobe_code", 32'(last_code), 32'h5);
    chk("k5_code", 32'(kif.key_code), 32'h5);
    chk("k5_held", 32'(kif.key_held), 32'd1);
    chk("k5_col_frozen", 32'(kif.cols), 32'hD);
    pressed = 16'h0000;
    step(4);
    chk("k5_held_rel_db", 32'(kif.key_held), 32'd1);
    step(1);
    chk("k5_released", 32'(kif.key_held), 32'd0);
    chk("k5_next_col", 32'(kif.cols), 32'hB);

    // Bouncy press of D (r3,c3): bounce lands inside press debounce
    wait_cols(4'b0111);
    step(3);
    base = valid_cnt;
    pressed = 16'h0001 << 15;
    step(2);
    pressed = 16'h0000;
    step(1);
    chk("kd_bounce_no_strobe", 32'(valid_cnt - base), 32'd0);
    chk("kd_bounce_rescan", 32'(kif.cols), 32'hE);
    pressed = 16'h0001 << 15;
    step(30);
    chk("kd_strobes", 32'(valid_cnt - base), 32'd1);
    chk("kd_code", 32'(kif.key_code), 32'hD);
    pressed = 16'h0000;
    step(6);
    chk("kd_released", 32'(kif.key_held), 32'd0);

    // Release bounce on 0 (r3,c1)
    base = valid_cnt;
    pressed = 16'h0001 << 13;
    step(30);
    chk("k0_strobes", 32'(valid_cnt - base), 32'd1);
    chk("k0_strobe_code", 32'(last_code), 32'h0);
    pressed = 16'h0000;
    step(2);
    pressed = 16'h0001 << 13;
    step(10);
    chk("k0_rel_bounce_strobes", 32'(valid_cnt - base), 32'd1);
    chk("k0_rel_bounce_held", 32'(kif.key_held), 32'd1);
    pressed = 16'h0000;
    step(6);
    chk("k0_released", 32'(kif.key_held), 32'd0);

    // Hold 1 (r0,c0), then add 3 (r0,c2)
    base = valid_cnt;
    pressed = 16'h0001;
    step(30);
    chk("k1_strobes", 32'(valid_cnt - base), 32'd1);
    chk("k1_code", 32'(kif.key_code), 32'h1);
    pressed = 16'h0005;
    step(20);
    chk("k1k3_no_strobe", 32'(valid_cnt - base), 32'd1);
    chk("k1k3_code", 32'(kif.key_code), 32'h1);
    chk("k1k3_held", 32'(kif.key_held), 32'd1);
    pressed = 16'h0000;
    step(6);
    chk("k1k3_released", 32'(kif.key_held), 32'd0);
    pressed = 16'h0004;
    step(30);
    chk("k3_strobes", 32'(valid_cnt - base), 32'd2);
    chk("k3_code", 32'(kif.key_code), 32'h3);
    pressed = 16'h0000;
    step(6);

    // Two rows on one column: 2 (r0,c1) and 8 (r2,c1)
    base = valid_cnt;
    pressed = 16'h0202;
    step(40);
    chk("k2k8_no_strobe", 32'(valid_cnt - base), 32'd0);
    chk("k2k8_not_held", 32'(kif.key_held), 32'd0);
    wait_cols(4'b1101);
    step(4);
    chk("k2k8_scan_advances", 32'(kif.cols), 32'hB);
    pressed = 16'h0000;

    // Reset during press debounce of A (r0,c3)
    wait_cols(4'b0111);
    step(3);
    base = valid_cnt;
    pressed = 16'h0008;
    step(2);
    reset = 1'b1;
    step(1);
    chk("ka_rst_cols", 32'(kif.cols), 32'hE);
    chk("ka_rst_valid", 32'(kif.key_valid), 32'd0);
    chk("ka_rst_code", 32'(kif.key_code), 32'h0);
    pressed = 16'h0000;
    reset = 1'b0;
    step(10);
    chk("ka_no_strobe", 32'(valid_cnt - base), 32'd0);
    chk("ka_not_held", 32'(kif.key_held), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
